// File: rtl/loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state encoding
// and the framing constants of the byte protocol.
package loader_pkg;

    localparam logic [2:0] ST_LEN   = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_CSUM  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    localparam int         HDR_BYTES  = 4;
    localparam int         WORD_BYTES = 4;
    localparam logic [7:0] CSUM_INIT  = 8'h00;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian byte-to-word assembler: shifts bytes in from the top so that
// byte k of a group of four ends up in bits [8k+7:8k].
module loader_word_asm
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic [31:0] word_next,
    output logic [1:0]  byte_cnt,
    output logic        word_last
);

    logic [31:0] shreg;
    logic [1:0]  cnt;

    // word_next lets the caller see a completed word in the same cycle its
    // last byte is accepted (the header length check depends on this).
    assign word_next = {byte_data, shreg[31:8]};
    assign word_last = byte_valid && (cnt == 2'(WORD_BYTES - 1));
    assign word      = shreg;
    assign byte_cnt  = cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (byte_valid) begin
            shreg <= word_next;
            cnt   <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program from a byte source into
// BRAM port A and holds the core in reset until the image is verified.
module imem_loader
    import loader_pkg::*;
#(
    parameter int          MAX_WORDS      = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        core_rst_n,
    output logic        done,
    output logic        err
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]       state, state_next;
    logic [IDX_W-1:0] idx, idx_inc, n_words;
    logic [7:0]       csum;
    logic [TMO_W-1:0] tmo;
    logic             done_r, err_r, core_rst_n_r;

    logic        accept, asm_valid, word_last, tmo_en, tmo_hit;
    logic [31:0] word, word_next;
    logic [1:0]  byte_cnt;

    assign rx_ready  = (state != ST_WRITE);
    assign accept    = rx_valid && rx_ready;
    assign asm_valid = accept && ((state == ST_LEN) || (state == ST_DATA));
    assign idx_inc   = idx + IDX_W'(1);

    loader_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (asm_valid),
        .byte_data  (rx_data),
        .word       (word),
        .word_next  (word_next),
        .byte_cnt   (byte_cnt),
        .word_last  (word_last)
    );

    // The idle timer only runs while a load is actually in progress.
    assign tmo_en  = (state == ST_DATA) || (state == ST_CSUM) ||
                     ((state == ST_LEN) && (byte_cnt != 2'd0));
    assign tmo_hit = tmo_en && !accept && (tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_LEN: begin
                if (word_last) begin
                    if ((word_next == '0) || (word_next > 32'(MAX_WORDS)))
                        state_next = ST_ERR;
                    else
                        state_next = ST_DATA;
                end
            end
            ST_DATA:  if (word_last) state_next = ST_WRITE;
            ST_WRITE: state_next = (idx_inc == n_words) ? ST_CSUM : ST_DATA;
            ST_CSUM: begin
                if (accept)
                    state_next = (rx_data == csum) ? ST_DONE : ST_ERR;
            end
            ST_DONE:  state_next = ST_DONE;
            ST_ERR:   state_next = ST_ERR;
            default:  state_next = ST_ERR;
        endcase
        if (tmo_hit)
            state_next = ST_ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_LEN;
            idx          <= '0;
            n_words      <= '0;
            csum         <= CSUM_INIT;
            tmo          <= '0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            core_rst_n_r <= 1'b0;
        end else begin
            state        <= state_next;
            done_r       <= (state_next == ST_DONE);
            err_r        <= (state_next == ST_ERR);
            core_rst_n_r <= (state_next == ST_DONE);

            // Out-of-range lengths go straight to ERR, so truncation is harmless.
            if ((state == ST_LEN) && word_last)
                n_words <= word_next[IDX_W-1:0];
            if ((state == ST_DATA) && accept)
                csum <= csum ^ rx_data;
            if (state == ST_WRITE)
                idx <= idx_inc;

            if (accept)
                tmo <= '0;
            else if (tmo_en && (tmo != TMO_W'(TIMEOUT_CYCLES)))
                tmo <= tmo + TMO_W'(1);
        end
    end

    assign mem_we     = (state == ST_WRITE) ? 4'b1111 : 4'b0000;
    assign mem_addr   = BASE_ADDR + (32'(idx) << 2);
    assign mem_din    = word;
    assign done       = done_r;
    assign err        = err_r;
    assign core_rst_n = core_rst_n_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed protocol cases plus random
// loads compared against a stream-level reference model.
module tb_imem_loader;

    localparam int          MAXW = 8;
    localparam int          TMO  = 16;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        core_rst_n;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    imem_loader #(
        .MAX_WORDS      (MAXW),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int stall_cnt = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [3:0]  got_we[$];

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_done, exp_err;

    logic [7:0]  stim[$];

    // Observe write strobes and stall cycles half a cycle away from the edge.
    always @(negedge clk) begin
        if (mem_we !== 4'b0000) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_din);
            got_we.push_back(mem_we);
        end
        if (rx_ready !== 1'b1) stall_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"},   32'(rx_ready),   32'd1);
        check({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check({tag, "_mem_addr"},   mem_addr,        BASE);
        check({tag, "_mem_din"},    mem_din,         32'd0);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
    endtask

    // Called at #1 after an edge; returns at #1 after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int tries;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        tries    = 0;
        do begin
            acc = rx_ready;
            @(posedge clk); #1;
            tries++;
        end while (!acc && tries < 20);
        if (!acc) check("byte_accept_bound", 32'd0, 32'd1);
    endtask

    task automatic send_stream(input int max_gap);
        for (int i = 0; i < stim.size(); i++)
            send_byte(stim[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
        rx_valid = 1'b0;
    endtask

    // Reference model: interprets the byte stream by the protocol rules.
    task automatic model();
        int unsigned n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (stim.size() < 4) return;
        n = {stim[3], stim[2], stim[1], stim[0]};
        if (n == 0 || n > MAXW) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < int'(n); i++) begin
            if (stim.size() < 8 + 4 * i) return;
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w = w | (32'(stim[4 + 4 * i + k]) << (8 * k));
                x = x ^ stim[4 + 4 * i + k];
            end
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back(w);
        end
        if (stim.size() > 4 + 4 * n) begin
            exp_done = (stim[4 + 4 * n] == x);
            exp_err  = !exp_done;
        end
    endtask

    task automatic compare_run(input string tag, input int base_idx);
        int got_n;
        got_n = got_addr.size() - base_idx;
        check({tag, "_nwrites"}, 32'(got_n), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_addr[base_idx + i], exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), got_data[base_idx + i], exp_data[i]);
            check($sformatf("%s_we%0d",   tag, i), 32'(got_we[base_idx + i]), 32'hF);
        end
        check({tag, "_done"},       32'(done),       32'(exp_done));
        check({tag, "_err"},        32'(err),        32'(exp_err));
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(exp_done));
    endtask

    task automatic build_random(input int n, input bit good);
        logic [7:0] x;
        stim.delete();
        for (int k = 0; k < 4; k++) stim.push_back(8'(n >> (8 * k)));
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            stim.push_back(8'($urandom));
            x = x ^ stim[stim.size() - 1];
        end
        stim.push_back(good ? x : (x ^ 8'(1 << $urandom_range(7, 0))));
    endtask

    initial begin
        int base_idx, s0, n;
        bit good;

        do_reset();
        check_reset_vals("reset");

        // Known-good two-word image, rx_valid held high throughout.
        stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h31};
        model();
        check("golden_model_w1", exp_data[1], 32'hDEADBEEF);
        base_idx = got_addr.size();
        s0 = stall_cnt;
        send_stream(0);
        check("b2b_stalls", 32'(stall_cnt - s0), 32'd2);
        compare_run("golden", base_idx);

        // Bad checksum: words still land, load fails.
        do_reset();
        stim[12] = 8'h30;
        model();
        base_idx = got_addr.size();
        send_stream(2);
        compare_run("badcsum", base_idx);

        // Zero-length header fails as soon as the 4th byte is taken.
        do_reset();
        stim = '{8'h00, 8'h00, 8'h00, 8'h00};
        model();
        base_idx = got_addr.size();
        send_stream(0);
        compare_run("zero_len", base_idx);

        // Length one past the limit.
        do_reset();
        stim = '{8'(MAXW + 1), 8'h00, 8'h00, 8'h00};
        model();
        base_idx = got_addr.size();
        send_stream(1);
        compare_run("over_len", base_idx);

        // Idle timeout mid-word: 15 idle cycles is fine, the 16th fails.
        do_reset();
        stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55};
        base_idx = got_addr.size();
        send_stream(0);
        repeat (TMO - 1) begin @(posedge clk); #1; end
        check("tmo_before_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_core_rst_n", 32'(core_rst_n), 32'd0);
        check("tmo_nwrites", 32'(got_addr.size() - base_idx), 32'd0);

        // Reset in the middle of a load, then a clean load.
        do_reset();
        stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
        send_stream(0);
        do_reset();
        check_reset_vals("midrst");
        stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h31};
        model();
        base_idx = got_addr.size();
        send_stream(1);
        compare_run("after_rst", base_idx);

        // Bytes after DONE are ignored.
        stim = '{8'h01, 8'h00};
        send_stream(0);
        compare_run("post_done", base_idx);

        // Random images, including the maximum length.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            n    = (t == 0) ? MAXW : int'($urandom_range(MAXW, 1));
            good = (t < 2) ? 1'b1 : 1'($urandom);
            build_random(n, good);
            model();
            base_idx = got_addr.size();
            send_stream(3);
            compare_run($sformatf("rand%0d", t), base_idx);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 1024: largest accepted program length, in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0: byte address of the first program word.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles allowed between bytes once a load has started.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port rx_valid, input, 1: byte available on rx_data.
REQ-008 Port rx_data, input, 8: received byte.
REQ-009 Port rx_ready, output, 1: loader can take a byte; a byte transfers on any cycle where rx_valid && rx_ready.
REQ-010 Port mem_we, output, 4: per-byte write enables to BRAM port A.
REQ-011 Port mem_addr, output, 32: byte address for the write, always word aligned.
REQ-012 Port mem_din, output, 32: write data word.
REQ-013 Port core_rst_n, output, 1: active-low hold on the pipelined core; low until the load completes.
REQ-014 Port done, output, 1: load completed and checksum verified (sticky).
REQ-015 Port err, output, 1: load failed (sticky).

Function
REQ-016 Protocol: 4-byte little-endian word count N, then 4N little-endian payload bytes, then 1 checksum byte equal to the XOR of all payload bytes.
REQ-017 FSM states are LEN, DATA, WRITE, CSUM, DONE and ERR; the reset state is LEN.
REQ-018 In LEN, after the 4th header byte: if N==0 or N>MAX_WORDS, go to ERR; otherwise go to DATA with word index 0.
REQ-019 In DATA, byte k (0..3) of the current word lands in bits [8k+7:8k]; every payload byte is XORed into the running checksum.
REQ-020 After the 4th byte of a word, go to WRITE for exactly one cycle.
REQ-021 WRITE cycle drives: mem_we=4'b1111, mem_addr=BASE_ADDR+4*index, mem_din=assembled word, rx_ready=0.
REQ-022 After WRITE, increment the index: if index==N go to CSUM, otherwise return to DATA.
REQ-023 mem_we SHALL be 4'b0000 in every cycle other than WRITE.
REQ-024 In CSUM, one received byte: if it equals the running checksum go to DONE, otherwise go to ERR.
REQ-025 rx_ready=1 in LEN, DATA, CSUM, DONE and ERR; bytes received in DONE or ERR are discarded.
REQ-026 Timeout counter: cleared on every accepted byte, counts while in DATA or CSUM, or in LEN after at least one header byte.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES, go to ERR.
REQ-028 DONE: done=1, core_rst_n=1, both registered; only rst leaves DONE.
REQ-029 ERR: err=1, core_rst_n=0; only rst leaves ERR.
REQ-030 Latency: core_rst_n rises one cycle after the checksum byte is accepted.
REQ-031 Bytes arriving back-to-back (rx_valid held high) SHALL all be accepted with no loss; the only stall is the one-cycle rx_ready=0 per word.
REQ-032 The checksum uses an 8-bit XOR; the word index and timeout counter are sized by $clog2 of their limits and never wrap.

Reset
REQ-033 With rst high at a clock edge: state=LEN, counters and checksum cleared, partial word discarded.
REQ-034 Output reset values: rx_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_din=0, core_rst_n=0, done=0, err=0.
REQ-035 Reset in the middle of a load SHALL NOT undo words already written; the next load overwrites from BASE_ADDR.

Structure
REQ-036 The FSM state encoding and the protocol constants (header length 4, checksum init 8'h00) SHALL live in shared package loader_pkg.
REQ-037 Byte-to-word assembly (byte counter plus shift register) SHALL be one sub-module, loader_word_asm; the FSM, index counter, timeout and checksum stay in imem_loader.

Verification
REQ-038 Bytes 02 00 00 00 13 00 00 00 EF BE AD DE 31 -> write 0x00000013 @0x0 and 0xDEADBEEF @0x4; then done=1, core_rst_n=1, err=0.
REQ-039 Header 00 00 00 00 -> err=1 the cycle after the 4th byte; no mem_we activity; core_rst_n=0.
REQ-040 Same stream as REQ-038 but checksum 0x30 -> both words written, err=1, done=0, core_rst_n=0.
REQ-041 TIMEOUT_CYCLES=16, header 01 00 00 00 plus 2 payload bytes, then idle -> err=1 after 16 idle cycles; no write.
REQ-042 rst pulsed after 6 bytes of the REQ-038 stream, then the full REQ-038 stream -> reset values restored, then a clean load with done=1.
REQ-043 REQ-038 stream with rx_valid held high throughout -> rx_ready=0 for exactly 2 cycles total; all 13 bytes accepted.
